// File: rtl/apb_arbiter2.sv
// Purpose : two-requester round-robin APB arbiter sharing one downstream completer path.
// Latency : grant edge -> SETUP, +1 ACCESS, DONE (winner pready) one cycle after out_pready or timeout.
// Backpres: requesters hold psel/addr/control until their pready; the loser waits, the downstream stalls via out_pready.
//
// Ports:
//   clock, reset_n            sole clock, synchronous active-low reset
//   inN_psel/penable/paddr/pprot/pwrite/pwdata/pstrb   upstream requester N (N = 0,1)
//   inN_pready/prdata/pslverr registered response to requester N (winner only)
//   out_psel/penable/paddr/pprot/pwrite/pwdata/pstrb   registered downstream request
//   out_pready/prdata/pslverr downstream response
module apb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        in0_psel,
    input  logic        in0_penable,
    input  logic [31:0] in0_paddr,
    input  logic [2:0]  in0_pprot,
    input  logic        in0_pwrite,
    input  logic [31:0] in0_pwdata,
    input  logic [3:0]  in0_pstrb,
    output logic        in0_pready,
    output logic [31:0] in0_prdata,
    output logic        in0_pslverr,

    input  logic        in1_psel,
    input  logic        in1_penable,
    input  logic [31:0] in1_paddr,
    input  logic [2:0]  in1_pprot,
    input  logic        in1_pwrite,
    input  logic [31:0] in1_pwdata,
    input  logic [3:0]  in1_pstrb,
    output logic        in1_pready,
    output logic [31:0] in1_prdata,
    output logic        in1_pslverr,

    output logic        out_psel,
    output logic        out_penable,
    output logic [31:0] out_paddr,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    // Last ACCESS cycle index before a forced error completion.
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam bit          TO_EN   = (TIMEOUT != 0);

    state_t      state, state_nxt;
    logic        last_grant, last_grant_nxt;
    logic        win, win_nxt;
    logic [15:0] tcnt, tcnt_nxt;

    logic        psel_nxt, penable_nxt;
    logic [31:0] paddr_nxt, pwdata_nxt;
    logic [2:0]  pprot_nxt;
    logic        pwrite_nxt;
    logic [3:0]  pstrb_nxt;

    logic        grant1;
    logic        cap_vld;
    logic [31:0] cap_dat;
    logic        cap_err;

    // psel alone qualifies a request; upstream penable carries no information here.
    logic unused_penable;
    assign unused_penable = in0_penable ^ in1_penable;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        win_nxt        = win;
        tcnt_nxt       = tcnt;
        psel_nxt       = 1'b0;
        penable_nxt    = 1'b0;
        paddr_nxt      = out_paddr;
        pprot_nxt      = out_pprot;
        pwrite_nxt     = out_pwrite;
        pwdata_nxt     = out_pwdata;
        pstrb_nxt      = out_pstrb;
        grant1         = 1'b0;
        cap_vld        = 1'b0;
        cap_dat        = 32'd0;
        cap_err        = 1'b0;

        case (state)
            IDLE: begin
                if (in0_psel || in1_psel) begin
                    // in1 wins if alone, or on a tie when in0 had the previous grant.
                    grant1         = in1_psel && (!in0_psel || (last_grant == 1'b0));
                    win_nxt        = grant1;
                    last_grant_nxt = grant1;
                    paddr_nxt      = grant1 ? in1_paddr  : in0_paddr;
                    pprot_nxt      = grant1 ? in1_pprot  : in0_pprot;
                    pwrite_nxt     = grant1 ? in1_pwrite : in0_pwrite;
                    pwdata_nxt     = grant1 ? in1_pwdata : in0_pwdata;
                    pstrb_nxt      = grant1 ? in1_pstrb  : in0_pstrb;
                    psel_nxt       = 1'b1;
                    state_nxt      = SETUP;
                end
            end
            SETUP: begin
                psel_nxt    = 1'b1;
                penable_nxt = 1'b1;
                tcnt_nxt    = 16'd0;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                psel_nxt    = 1'b1;
                penable_nxt = 1'b1;
                // A real completion on the timeout cycle takes priority over the forced error.
                if (out_pready) begin
                    cap_vld     = 1'b1;
                    cap_dat     = out_prdata;
                    cap_err     = out_pslverr;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    state_nxt   = DONE;
                end else if (TO_EN && (tcnt == TO_LAST)) begin
                    cap_vld     = 1'b1;
                    cap_dat     = 32'd0;
                    cap_err     = 1'b1;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    state_nxt   = DONE;
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            win         <= 1'b0;
            tcnt        <= 16'd0;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            out_paddr   <= 32'd0;
            out_pprot   <= 3'd0;
            out_pwrite  <= 1'b0;
            out_pwdata  <= 32'd0;
            out_pstrb   <= 4'd0;
            in0_pready  <= 1'b0;
            in0_prdata  <= 32'd0;
            in0_pslverr <= 1'b0;
            in1_pready  <= 1'b0;
            in1_prdata  <= 32'd0;
            in1_pslverr <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            win         <= win_nxt;
            tcnt        <= tcnt_nxt;
            out_psel    <= psel_nxt;
            out_penable <= penable_nxt;
            out_paddr   <= paddr_nxt;
            out_pprot   <= pprot_nxt;
            out_pwrite  <= pwrite_nxt;
            out_pwdata  <= pwdata_nxt;
            out_pstrb   <= pstrb_nxt;
            in0_pready  <= cap_vld && !win;
            in1_pready  <= cap_vld && win;
            // Response data is kept per requester so the loser's last value is untouched.
            if (cap_vld && !win) begin
                in0_prdata  <= cap_dat;
                in0_pslverr <= cap_err;
            end
            if (cap_vld && win) begin
                in1_prdata  <= cap_dat;
                in1_pslverr <= cap_err;
            end
        end
    end

endmodule

// File: tb/tb_apb_arbiter2.sv
// Purpose : directed + randomized checking of apb_arbiter2 against a transaction-level model.
// Latency : n/a (testbench).
// Backpres: bench plays both requesters and a downstream completer with programmable wait states.
module tb_apb_arbiter2;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in0_psel, in0_penable, in0_pwrite, in0_pready, in0_pslverr;
    logic [31:0] in0_paddr, in0_pwdata, in0_prdata;
    logic [2:0]  in0_pprot;
    logic [3:0]  in0_pstrb;
    logic        in1_psel, in1_penable, in1_pwrite, in1_pready, in1_pslverr;
    logic [31:0] in1_paddr, in1_pwdata, in1_prdata;
    logic [2:0]  in1_pprot;
    logic [3:0]  in1_pstrb;
    logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic [2:0]  out_pprot;
    logic [3:0]  out_pstrb;

    always #5 clock = ~clock;

    apb_arbiter2 #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .in0_psel(in0_psel), .in0_penable(in0_penable), .in0_paddr(in0_paddr),
        .in0_pprot(in0_pprot), .in0_pwrite(in0_pwrite), .in0_pwdata(in0_pwdata),
        .in0_pstrb(in0_pstrb), .in0_pready(in0_pready), .in0_prdata(in0_prdata),
        .in0_pslverr(in0_pslverr),
        .in1_psel(in1_psel), .in1_penable(in1_penable), .in1_paddr(in1_paddr),
        .in1_pprot(in1_pprot), .in1_pwrite(in1_pwrite), .in1_pwdata(in1_pwdata),
        .in1_pstrb(in1_pstrb), .in1_pready(in1_pready), .in1_prdata(in1_prdata),
        .in1_pslverr(in1_pslverr),
        .out_psel(out_psel), .out_penable(out_penable), .out_paddr(out_paddr),
        .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level model state.
    bit          pend [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    logic [2:0]  r_prot [2];
    logic        r_write [2];
    logic [3:0]  r_strb [2];
    int          last_g;
    logic [31:0] m_prdata [2];
    logic        m_err [2];
    int          grants [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_in();
        in0_psel = pend[0]; in0_penable = pend[0]; in0_paddr = r_addr[0];
        in0_pprot = r_prot[0]; in0_pwrite = r_write[0]; in0_pwdata = r_wdata[0];
        in0_pstrb = r_strb[0];
        in1_psel = pend[1]; in1_penable = pend[1]; in1_paddr = r_addr[1];
        in1_pprot = r_prot[1]; in1_pwrite = r_write[1]; in1_pwdata = r_wdata[1];
        in1_pstrb = r_strb[1];
    endtask

    task automatic new_req(input int n, input logic [31:0] a, input logic w, input logic [31:0] d);
        pend[n]    = 1'b1;
        r_addr[n]  = a;
        r_write[n] = w;
        r_wdata[n] = d;
        r_prot[n]  = 3'($urandom);
        r_strb[n]  = 4'($urandom);
        drive_in();
    endtask

    task automatic check_out_zero(input string tag);
        chk({tag, "_psel"},    out_psel, 0);
        chk({tag, "_penable"}, out_penable, 0);
        chk({tag, "_paddr"},   out_paddr, 0);
        chk({tag, "_pwdata"},  out_pwdata, 0);
        chk({tag, "_ctl"},     {out_pprot, out_pwrite, out_pstrb}, 0);
        chk({tag, "_rdy"},     {in0_pready, in1_pready}, 0);
        chk({tag, "_rd0"},     in0_prdata, 0);
        chk({tag, "_rd1"},     in1_prdata, 0);
        chk({tag, "_err"},     {in0_pslverr, in1_pslverr}, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_in();
        out_pready = 1'b0; out_prdata = 32'd0; out_pslverr = 1'b0;
        edge_();
        check_out_zero("reset");
        reset_n     = 1'b1;
        last_g      = 1;
        m_prdata[0] = 0; m_prdata[1] = 0;
        m_err[0]    = 0; m_err[1]    = 0;
    endtask

    // Called at a negedge while the arbiter is idle with at least one request pending.
    // The completer answers on ACCESS cycle index 'waits' (never, if waits >= TO).
    task automatic xfer(input int waits, input logic [31:0] rd, input logic er, input bit drop);
        int          w;
        int          acc_len;
        logic [31:0] exp_d;
        logic        exp_e;
        if (pend[0] && pend[1]) w = (last_g == 1) ? 0 : 1;
        else                    w = pend[0] ? 0 : 1;
        last_g = w;
        grants.push_back(w);
        if (waits <= TO - 1) begin
            acc_len = waits + 1; exp_d = rd; exp_e = er;
        end else begin
            acc_len = TO; exp_d = 32'd0; exp_e = 1'b1;
        end

        edge_();
        chk("setup_psel",    out_psel, 1);
        chk("setup_penable", out_penable, 0);
        chk("setup_paddr",   out_paddr, r_addr[w]);
        chk("setup_pwdata",  out_pwdata, r_wdata[w]);
        chk("setup_ctl",     {out_pprot, out_pwrite, out_pstrb}, {r_prot[w], r_write[w], r_strb[w]});
        if (drop) begin
            pend[w] = 1'b0;
            drive_in();
        end
        edge_();
        for (int k = 0; k < acc_len; k++) begin
            chk("acc_psel_en", {out_psel, out_penable}, 2'b11);
            chk("acc_paddr",   out_paddr, r_addr[w]);
            chk("acc_rdy",     {in0_pready, in1_pready}, 0);
            out_pready  = (k == waits);
            out_prdata  = (k == waits) ? rd : $urandom;
            out_pslverr = (k == waits) ? er : 1'($urandom);
            edge_();
        end
        out_pready = 1'b0;

        m_prdata[w] = exp_d;
        m_err[w]    = exp_e;
        chk("done_psel_en", {out_psel, out_penable}, 0);
        chk("done_rdy",     {in1_pready, in0_pready}, (w == 1) ? 2'b10 : 2'b01);
        chk("done_rd0",     in0_prdata, m_prdata[0]);
        chk("done_rd1",     in1_prdata, m_prdata[1]);
        chk("done_err",     {in1_pslverr, in0_pslverr}, {m_err[1], m_err[0]});
        pend[w] = 1'b0;
        drive_in();
        edge_();
        chk("idle_psel", out_psel, 0);
        chk("idle_rdy",  {in0_pready, in1_pready}, 0);
    endtask

    initial begin
        out_pready = 1'b0; out_prdata = 32'd0; out_pslverr = 1'b0;
        for (int n = 0; n < 2; n++) begin
            r_addr[n] = 0; r_wdata[n] = 0; r_prot[n] = 0; r_write[n] = 0; r_strb[n] = 0;
        end
        do_reset();

        // Single zero-wait read on in0.
        new_req(0, 32'h0000_0100, 1'b0, 32'd0);
        xfer(0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Simultaneous writes right after reset: in0 then in1.
        do_reset();
        new_req(0, 32'h0000_1000, 1'b1, 32'h1111_1111);
        new_req(1, 32'h0000_2000, 1'b1, 32'h2222_2222);
        xfer(0, 32'h0, 1'b0, 1'b0);
        chk("tie_first", grants[$], 0);
        xfer(1, 32'h0, 1'b0, 1'b0);
        chk("tie_second", grants[$], 1);

        // Both requesting continuously: grants alternate.
        grants.delete();
        for (int i = 0; i < 6; i++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n]) new_req(n, $urandom, 1'($urandom), $urandom);
            xfer($urandom_range(0, 2), $urandom, 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) chk("alternate", grants[i], i % 2);

        // Three wait states with error.
        if (!pend[0] && !pend[1]) new_req(1, 32'h0000_3000, 1'b0, 32'd0);
        xfer(3, 32'hCAFE_F00D, 1'b1, 1'b0);

        // Timeout on one requester, then the other gets serviced.
        for (int n = 0; n < 2; n++)
            if (!pend[n]) new_req(n, $urandom, 1'($urandom), $urandom);
        xfer(1000, 32'h1234_5678, 1'b0, 1'b0);
        xfer(0, 32'h8765_4321, 1'b0, 1'b0);

        // Winner drops psel mid-transfer: response still delivered.
        if (!pend[0] && !pend[1]) new_req(0, 32'h0000_4000, 1'b0, 32'd0);
        xfer(2, 32'hA5A5_5A5A, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n] && $urandom_range(0, 1) == 1) new_req(n, $urandom, 1'($urandom), $urandom);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)), $urandom, 1'($urandom), $urandom);
            xfer($urandom_range(0, 9), $urandom, 1'($urandom), $urandom_range(0, 7) == 0);
        end

        // Reset in the middle of ACCESS.
        for (int n = 0; n < 2; n++)
            if (!pend[n]) new_req(n, $urandom, 1'($urandom), $urandom);
        edge_();
        edge_();
        chk("pre_rst_access", {out_psel, out_penable}, 2'b11);
        do_reset();
        new_req(0, 32'h0000_5000, 1'b0, 32'd0);
        new_req(1, 32'h0000_6000, 1'b0, 32'd0);
        xfer(0, 32'h0BAD_CAFE, 1'b0, 1'b0);
        chk("post_rst_grant", grants[$], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
